// File: rtl/alu_arbiter.sv
// Two-port arbiter in front of a single combinational ALU.
// One request is accepted, executed for one cycle, then its registered result is returned.
module alu_arbiter #(
    parameter int unsigned XLEN          = 32,
    parameter int unsigned PIPE_PRIORITY = 0,
    parameter int unsigned CNT_W         = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,

    input  logic             p_valid_i,
    input  logic [6:0]       p_opcode_i,
    input  logic [2:0]       p_fun3_i,
    input  logic [6:0]       p_fun7_i,
    input  logic [XLEN-1:0]  p_a_i,
    input  logic [XLEN-1:0]  p_b_i,
    output logic             p_ready_o,
    output logic             p_rvalid_o,
    input  logic             p_rready_i,
    output logic [XLEN-1:0]  p_result_o,
    output logic             p_rerr_o,

    input  logic             u_valid_i,
    input  logic [6:0]       u_opcode_i,
    input  logic [2:0]       u_fun3_i,
    input  logic [6:0]       u_fun7_i,
    input  logic [XLEN-1:0]  u_a_i,
    input  logic [XLEN-1:0]  u_b_i,
    output logic             u_ready_o,
    output logic             u_rvalid_o,
    input  logic             u_rready_i,
    output logic [XLEN-1:0]  u_result_o,
    output logic             u_rerr_o,

    output logic             alu_op_o,
    output logic [6:0]       alu_opcode_o,
    output logic [2:0]       alu_fun3_o,
    output logic [6:0]       alu_fun7_o,
    output logic [XLEN-1:0]  alu_a_o,
    output logic [XLEN-1:0]  alu_b_o,
    input  logic [XLEN-1:0]  alu_out_i,

    output logic [CNT_W-1:0] op_count_o
);

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

    localparam logic OwnP = 1'b0;
    localparam logic OwnU = 1'b1;

    state_e            state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_grant_q, last_grant_d;
    logic [6:0]        opcode_q, opcode_d;
    logic [2:0]        fun3_q, fun3_d;
    logic [6:0]        fun7_q, fun7_d;
    logic [XLEN-1:0]   a_q, a_d;
    logic [XLEN-1:0]   b_q, b_d;
    logic [XLEN-1:0]   p_result_q, p_result_d;
    logic [XLEN-1:0]   u_result_q, u_result_d;
    logic              p_rerr_q, p_rerr_d;
    logic              u_rerr_q, u_rerr_d;
    logic [CNT_W-1:0]  op_count_q, op_count_d;

    logic              grant_p, grant_u;
    logic              supported;
    logic              owner_rready;

    function automatic logic op_supported(input logic [6:0] op);
        case (op)
            7'b0110011, 7'b0010011, 7'b0000011,
            7'b0100011, 7'b1100011, 7'b0110111,
            7'b0010111, 7'b1101111, 7'b1100111: op_supported = 1'b1;
            default:                            op_supported = 1'b0;
        endcase
    endfunction

    // Round-robin favours whoever was not served last; last_grant resets to U so P wins first.
    always_comb begin
        grant_p = 1'b0;
        grant_u = 1'b0;
        if (p_valid_i && u_valid_i) begin
            if (PIPE_PRIORITY != 0 || last_grant_q == OwnU) begin
                grant_p = 1'b1;
            end else begin
                grant_u = 1'b1;
            end
        end else begin
            grant_p = p_valid_i;
            grant_u = u_valid_i;
        end
    end

    assign p_ready_o = (state_q == StIdle) && grant_p && !rst_i;
    assign u_ready_o = (state_q == StIdle) && grant_u && !rst_i;

    assign supported    = op_supported(opcode_q);
    assign owner_rready = (owner_q == OwnP) ? p_rready_i : u_rready_i;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        opcode_d     = opcode_q;
        fun3_d       = fun3_q;
        fun7_d       = fun7_q;
        a_d          = a_q;
        b_d          = b_q;
        p_result_d   = p_result_q;
        u_result_d   = u_result_q;
        p_rerr_d     = p_rerr_q;
        u_rerr_d     = u_rerr_q;
        op_count_d   = op_count_q;

        case (state_q)
            StIdle: begin
                if (p_ready_o) begin
                    opcode_d = p_opcode_i;
                    fun3_d   = p_fun3_i;
                    fun7_d   = p_fun7_i;
                    a_d      = p_a_i;
                    b_d      = p_b_i;
                    owner_d  = OwnP;
                    state_d  = StExec;
                end else if (u_ready_o) begin
                    opcode_d = u_opcode_i;
                    fun3_d   = u_fun3_i;
                    fun7_d   = u_fun7_i;
                    a_d      = u_a_i;
                    b_d      = u_b_i;
                    owner_d  = OwnU;
                    state_d  = StExec;
                end
            end
            StExec: begin
                // Per-port result registers let the non-owner keep its last delivered response.
                if (owner_q == OwnP) begin
                    p_result_d = supported ? alu_out_i : '0;
                    p_rerr_d   = !supported;
                end else begin
                    u_result_d = supported ? alu_out_i : '0;
                    u_rerr_d   = !supported;
                end
                state_d = StResp;
            end
            StResp: begin
                if (owner_rready) begin
                    last_grant_d = owner_q;
                    op_count_d   = op_count_q + CNT_W'(1);
                    state_d      = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            owner_q      <= OwnP;
            last_grant_q <= OwnU;
            opcode_q     <= '0;
            fun3_q       <= '0;
            fun7_q       <= '0;
            a_q          <= '0;
            b_q          <= '0;
            p_result_q   <= '0;
            u_result_q   <= '0;
            p_rerr_q     <= 1'b0;
            u_rerr_q     <= 1'b0;
            op_count_q   <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            opcode_q     <= opcode_d;
            fun3_q       <= fun3_d;
            fun7_q       <= fun7_d;
            a_q          <= a_d;
            b_q          <= b_d;
            p_result_q   <= p_result_d;
            u_result_q   <= u_result_d;
            p_rerr_q     <= p_rerr_d;
            u_rerr_q     <= u_rerr_d;
            op_count_q   <= op_count_d;
        end
    end

    assign p_rvalid_o = (state_q == StResp) && (owner_q == OwnP);
    assign u_rvalid_o = (state_q == StResp) && (owner_q == OwnU);
    assign p_result_o = p_result_q;
    assign u_result_o = u_result_q;
    assign p_rerr_o   = p_rerr_q;
    assign u_rerr_o   = u_rerr_q;

    assign alu_op_o     = (state_q == StExec) && supported;
    assign alu_opcode_o = opcode_q;
    assign alu_fun3_o   = fun3_q;
    assign alu_fun7_o   = fun7_q;
    assign alu_a_o      = a_q;
    assign alu_b_o      = b_q;

    assign op_count_o = op_count_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench: a round-robin arbiter and a P-priority arbiter share one stimulus stream.
module tb_alu_arbiter;

    logic        clk;
    logic        rst;
    logic        p_valid, u_valid, p_rready, u_rready;
    logic [6:0]  p_opcode, u_opcode, p_fun7, u_fun7;
    logic [2:0]  p_fun3, u_fun3;
    logic [31:0] p_a, p_b, u_a, u_b;

    logic        p_ready0, p_rvalid0, p_rerr0, u_ready0, u_rvalid0, u_rerr0, alu_op0;
    logic [31:0] p_result0, u_result0, alu_a0, alu_b0, alu_out0;
    logic [6:0]  alu_opcode0, alu_fun70;
    logic [2:0]  alu_fun30;
    logic [15:0] op_count0;

    logic        p_ready1, p_rvalid1, p_rerr1, u_ready1, u_rvalid1, u_rerr1, alu_op1;
    logic [31:0] p_result1, u_result1, alu_a1, alu_b1, alu_out1;
    logic [6:0]  alu_opcode1, alu_fun71;
    logic [2:0]  alu_fun31;
    logic [15:0] op_count1;

    int total = 0;
    int bad   = 0;

    function automatic logic [31:0] alu_model(input logic [6:0] op, input logic [2:0] f3,
                                              input logic [6:0] f7, input logic [31:0] a,
                                              input logic [31:0] b);
        case (op)
            7'b0110011: alu_model = (f3 == 3'b000 && f7 == 7'b0100000) ? a - b : a + b;
            7'b0110111: alu_model = b;
            default:    alu_model = a + b;
        endcase
    endfunction

    always_comb alu_out0 = alu_model(alu_opcode0, alu_fun30, alu_fun70, alu_a0, alu_b0);
    always_comb alu_out1 = alu_model(alu_opcode1, alu_fun31, alu_fun71, alu_a1, alu_b1);

    alu_arbiter #(.XLEN(32), .PIPE_PRIORITY(0), .CNT_W(16)) dut_rr (
        .clk_i(clk), .rst_i(rst),
        .p_valid_i(p_valid), .p_opcode_i(p_opcode), .p_fun3_i(p_fun3), .p_fun7_i(p_fun7),
        .p_a_i(p_a), .p_b_i(p_b), .p_ready_o(p_ready0), .p_rvalid_o(p_rvalid0),
        .p_rready_i(p_rready), .p_result_o(p_result0), .p_rerr_o(p_rerr0),
        .u_valid_i(u_valid), .u_opcode_i(u_opcode), .u_fun3_i(u_fun3), .u_fun7_i(u_fun7),
        .u_a_i(u_a), .u_b_i(u_b), .u_ready_o(u_ready0), .u_rvalid_o(u_rvalid0),
        .u_rready_i(u_rready), .u_result_o(u_result0), .u_rerr_o(u_rerr0),
        .alu_op_o(alu_op0), .alu_opcode_o(alu_opcode0), .alu_fun3_o(alu_fun30),
        .alu_fun7_o(alu_fun70), .alu_a_o(alu_a0), .alu_b_o(alu_b0), .alu_out_i(alu_out0),
        .op_count_o(op_count0)
    );

    alu_arbiter #(.XLEN(32), .PIPE_PRIORITY(1), .CNT_W(16)) dut_pp (
        .clk_i(clk), .rst_i(rst),
        .p_valid_i(p_valid), .p_opcode_i(p_opcode), .p_fun3_i(p_fun3), .p_fun7_i(p_fun7),
        .p_a_i(p_a), .p_b_i(p_b), .p_ready_o(p_ready1), .p_rvalid_o(p_rvalid1),
        .p_rready_i(p_rready), .p_result_o(p_result1), .p_rerr_o(p_rerr1),
        .u_valid_i(u_valid), .u_opcode_i(u_opcode), .u_fun3_i(u_fun3), .u_fun7_i(u_fun7),
        .u_a_i(u_a), .u_b_i(u_b), .u_ready_o(u_ready1), .u_rvalid_o(u_rvalid1),
        .u_rready_i(u_rready), .u_result_o(u_result1), .u_rerr_o(u_rerr1),
        .alu_op_o(alu_op1), .alu_opcode_o(alu_opcode1), .alu_fun3_o(alu_fun31),
        .alu_fun7_o(alu_fun71), .alu_a_o(alu_a1), .alu_b_o(alu_b1), .alu_out_i(alu_out1),
        .op_count_o(op_count1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_p(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [31:0] a, input logic [31:0] b);
        p_opcode = op; p_fun3 = f3; p_fun7 = f7; p_a = a; p_b = b;
    endtask

    task automatic set_u(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [31:0] a, input logic [31:0] b);
        u_opcode = op; u_fun3 = f3; u_fun7 = f7; u_a = a; u_b = b;
    endtask

    initial begin
        logic exp_u;
        rst = 1'b1;
        p_valid = 1'b0; u_valid = 1'b0; p_rready = 1'b0; u_rready = 1'b0;
        set_p(7'd0, 3'd0, 7'd0, 32'd0, 32'd0);
        set_u(7'd0, 3'd0, 7'd0, 32'd0, 32'd0);
        repeat (2) @(negedge clk);
        #1;
        chk("rst_p_ready", p_ready0, 1'b0);
        chk("rst_p_rvalid", p_rvalid0, 1'b0);
        chk("rst_u_rvalid", u_rvalid0, 1'b0);
        chk("rst_p_result", p_result0, 32'd0);
        chk("rst_u_rerr", u_rerr0, 1'b0);
        chk("rst_alu_op", alu_op0, 1'b0);
        chk("rst_alu_a", alu_a0, 32'd0);
        chk("rst_op_count", op_count0, 16'd0);
        rst = 1'b0;
        @(negedge clk);

        // P ADD 5 + 7
        set_p(7'b0110011, 3'b000, 7'b0000000, 32'd5, 32'd7);
        p_valid = 1'b1; p_rready = 1'b1; u_rready = 1'b1;
        #1;
        chk("add_p_ready", p_ready0, 1'b1);
        chk("add_u_ready", u_ready0, 1'b0);
        chk("add_alu_op_c0", alu_op0, 1'b0);
        @(negedge clk);
        p_valid = 1'b0;
        #1;
        chk("add_alu_op_c1", alu_op0, 1'b1);
        chk("add_alu_a", alu_a0, 32'd5);
        chk("add_alu_b", alu_b0, 32'd7);
        chk("add_rvalid_c1", p_rvalid0, 1'b0);
        @(negedge clk);
        #1;
        chk("add_rvalid_c2", p_rvalid0, 1'b1);
        chk("add_result", p_result0, 32'd12);
        chk("add_rerr", p_rerr0, 1'b0);
        chk("add_alu_op_c2", alu_op0, 1'b0);
        @(negedge clk);
        #1;
        chk("add_rvalid_c3", p_rvalid0, 1'b0);
        chk("add_op_count", op_count0, 16'd1);
        chk("add_result_hold", p_result0, 32'd12);

        // Contention from reset: P ADDI 1+1, U SUB 10-3, both held
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        set_p(7'b0010011, 3'b000, 7'b0000000, 32'd1, 32'd1);
        set_u(7'b0110011, 3'b000, 7'b0100000, 32'd10, 32'd3);
        p_valid = 1'b1; u_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            exp_u = (i % 2) == 1;
            #1;
            chk($sformatf("rr_p_ready_%0d", i), p_ready0, !exp_u);
            chk($sformatf("rr_u_ready_%0d", i), u_ready0, exp_u);
            chk($sformatf("pp_p_ready_%0d", i), p_ready1, 1'b1);
            chk($sformatf("pp_u_ready_%0d", i), u_ready1, 1'b0);
            @(negedge clk);
            @(negedge clk);
            #1;
            if (exp_u) begin
                chk($sformatf("rr_u_rvalid_%0d", i), u_rvalid0, 1'b1);
                chk($sformatf("rr_u_result_%0d", i), u_result0, 32'd7);
            end else begin
                chk($sformatf("rr_p_rvalid_%0d", i), p_rvalid0, 1'b1);
                chk($sformatf("rr_p_result_%0d", i), p_result0, 32'd2);
            end
            chk($sformatf("pp_p_rvalid_%0d", i), p_rvalid1, 1'b1);
            chk($sformatf("pp_p_result_%0d", i), p_result1, 32'd2);
            chk($sformatf("pp_u_rvalid_%0d", i), u_rvalid1, 1'b0);
            @(negedge clk);
        end
        p_valid = 1'b0; u_valid = 1'b0;
        #1;
        chk("rr_op_count", op_count0, 16'd6);
        chk("pp_op_count", op_count1, 16'd6);

        // U LUI with response backpressure
        set_u(7'b0110111, 3'b000, 7'b0000000, 32'd0, 32'h12345000);
        u_rready = 1'b0; u_valid = 1'b1;
        #1;
        chk("lui_u_ready", u_ready0, 1'b1);
        @(negedge clk);
        u_valid = 1'b0;
        @(negedge clk);
        #1;
        chk("lui_rvalid", u_rvalid0, 1'b1);
        chk("lui_result", u_result0, 32'h12345000);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            chk($sformatf("bp_rvalid_%0d", i), u_rvalid0, 1'b1);
            chk($sformatf("bp_result_%0d", i), u_result0, 32'h12345000);
            chk($sformatf("bp_p_rvalid_%0d", i), p_rvalid0, 1'b0);
        end
        u_rready = 1'b1;
        @(negedge clk);
        #1;
        chk("bp_released_rvalid", u_rvalid0, 1'b0);
        chk("bp_op_count", op_count0, 16'd7);

        // Illegal opcode from P
        set_p(7'b1111111, 3'b000, 7'b0000000, 32'd3, 32'd4);
        p_valid = 1'b1; p_rready = 1'b1;
        #1;
        chk("ill_p_ready", p_ready0, 1'b1);
        @(negedge clk);
        p_valid = 1'b0;
        #1;
        chk("ill_alu_op", alu_op0, 1'b0);
        @(negedge clk);
        #1;
        chk("ill_rvalid", p_rvalid0, 1'b1);
        chk("ill_rerr", p_rerr0, 1'b1);
        chk("ill_result", p_result0, 32'd0);
        @(negedge clk);
        #1;
        chk("ill_op_count", op_count0, 16'd8);

        // Reset during EXEC
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        set_p(7'b0110011, 3'b000, 7'b0000000, 32'd5, 32'd7);
        p_valid = 1'b1;
        #1;
        chk("rx_p_ready", p_ready0, 1'b1);
        @(negedge clk);
        p_valid = 1'b0;
        #1;
        chk("rx_alu_op_pre", alu_op0, 1'b1);
        rst = 1'b1;
        #1;
        chk("rx_alu_op", alu_op0, 1'b0);
        chk("rx_alu_a", alu_a0, 32'd0);
        chk("rx_op_count", op_count0, 16'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        chk("rx_no_resp", p_rvalid0, 1'b0);
        chk("rx_op_count_after", op_count0, 16'd0);

        // Reset during RESP
        p_valid = 1'b1; p_rready = 1'b0;
        #1;
        @(negedge clk);
        p_valid = 1'b0;
        @(negedge clk);
        #1;
        chk("rr_resp_rvalid", p_rvalid0, 1'b1);
        chk("rr_resp_result", p_result0, 32'd12);
        rst = 1'b1;
        #1;
        chk("rs_rvalid", p_rvalid0, 1'b0);
        chk("rs_result", p_result0, 32'd0);
        chk("rs_op_count", op_count0, 16'd0);
        @(negedge clk);
        rst = 1'b0;
        p_valid = 1'b1; u_valid = 1'b1;
        #1;
        chk("post_rst_p_wins", p_ready0, 1'b1);
        chk("post_rst_u_waits", u_ready0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
